// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : decode_issue_stage
// Purpose : Decode/issue stage with an N-entry register file, a per-register
//           pending-write scoreboard that raises its own stalls, and a
//           valid/ready decode-to-execute pipeline register.
// Options : DECODE_ISSUE_BYPASS_EN - forward a retiring writeback value to a
//           waiting consumer so it issues in the writeback cycle.
// Revision: 1.0 - initial release
// ============================================================================
module decode_issue_stage #(
  parameter int WIDTH      = 16,
  parameter int NUM_REGS   = 8,
  parameter int CTRL_WIDTH = 32,
  parameter int PEND_BITS  = 2,
  localparam int REG_BITS  = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [REG_BITS-1:0]   in_src1,
  input  logic [REG_BITS-1:0]   in_src2,
  input  logic [REG_BITS-1:0]   in_dest,
  input  logic                  in_uses_src1,
  input  logic                  in_uses_src2,
  input  logic                  in_writes_dest,
  input  logic [WIDTH-1:0]      in_imm,
  input  logic                  wb_valid,
  input  logic [REG_BITS-1:0]   wb_dest,
  input  logic [WIDTH-1:0]      wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [WIDTH-1:0]      out_sr1,
  output logic [WIDTH-1:0]      out_sr2,
  output logic [REG_BITS-1:0]   out_dest,
  output logic                  out_writes_dest,
  output logic [WIDTH-1:0]      out_imm,
  output logic                  stall
);

  localparam logic [PEND_BITS-1:0] c_PEND_MAX = {PEND_BITS{1'b1}};

  // Architectural state
  logic [WIDTH-1:0]      r_regs [NUM_REGS];
  logic [PEND_BITS-1:0]  r_pend [NUM_REGS];

  // Output pipeline register
  logic                  r_out_valid;
  logic [CTRL_WIDTH-1:0] r_out_ctrl;
  logic [WIDTH-1:0]      r_out_sr1;
  logic [WIDTH-1:0]      r_out_sr2;
  logic [REG_BITS-1:0]   r_out_dest;
  logic                  r_out_writes_dest;
  logic [WIDTH-1:0]      r_out_imm;

  // Combinational decode signals
  logic [WIDTH-1:0]      w_rd1;
  logic [WIDTH-1:0]      w_rd2;
  logic [PEND_BITS-1:0]  w_pend1;
  logic [PEND_BITS-1:0]  w_pend2;
  logic [PEND_BITS-1:0]  w_pend_d;
  logic                  w_haz1;
  logic                  w_haz2;
  logic                  w_haz_sat;
  logic                  w_hazard;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_squash_wr;
  logic [PEND_BITS-1:0]  w_pend_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]   w_underflow;

  assign w_pend1  = r_pend[in_src1];
  assign w_pend2  = r_pend[in_src2];
  assign w_pend_d = r_pend[in_dest];

  // Operand read and source hazard detection (optionally bypassing a retiring write)
  always_comb begin
    w_rd1  = r_regs[in_src1];
    w_rd2  = r_regs[in_src2];
    w_haz1 = in_uses_src1 & (w_pend1 != '0);
    w_haz2 = in_uses_src2 & (w_pend2 != '0);
`ifdef DECODE_ISSUE_BYPASS_EN
    // A retiring write that is the only one in flight satisfies the source
    if (wb_valid && (wb_dest == in_src1)) begin
      w_rd1 = wb_data;
      if (w_pend1 == PEND_BITS'(1)) w_haz1 = 1'b0;
    end
    if (wb_valid && (wb_dest == in_src2)) begin
      w_rd2 = wb_data;
      if (w_pend2 == PEND_BITS'(1)) w_haz2 = 1'b0;
    end
`endif
  end

  // Another writer to a saturated destination would overflow its counter
  assign w_haz_sat   = in_writes_dest & (w_pend_d == c_PEND_MAX);
  assign w_hazard    = w_haz1 | w_haz2 | w_haz_sat;
  assign w_ready     = ~reset & ~flush & ~w_hazard & (~r_out_valid | out_ready);
  assign w_accept    = in_valid & w_ready;
  assign w_squash_wr = flush & r_out_valid & r_out_writes_dest;

  assign in_ready = w_ready;
  assign stall    = in_valid & ~w_ready;

  // Per-register next pending count: +issue, -writeback, -squash, clamped at zero
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    logic               w_inc;
    logic               w_dec_wb;
    logic               w_dec_fl;
    logic [PEND_BITS:0] w_sum;
    logic [PEND_BITS:0] w_ndec;
    logic [PEND_BITS:0] w_diff;

    assign w_inc    = w_accept & in_writes_dest & (in_dest == REG_BITS'(g));
    assign w_dec_wb = wb_valid & (wb_dest == REG_BITS'(g));
    assign w_dec_fl = w_squash_wr & (r_out_dest == REG_BITS'(g));
    assign w_sum    = {1'b0, r_pend[g]} + (PEND_BITS+1)'(w_inc);
    assign w_ndec   = (PEND_BITS+1)'(w_dec_wb) + (PEND_BITS+1)'(w_dec_fl);
    assign w_diff   = w_sum - w_ndec;
    assign w_underflow[g] = (w_sum < w_ndec);
    assign w_pend_nxt[g]  = w_underflow[g] ? '0 : w_diff[PEND_BITS-1:0];
  end

  // Scoreboard register; an underflow means writeback retired an unissued write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_pend[i] <= w_pend_nxt[i];
`ifndef SYNTHESIS
        assert (!w_underflow[i])
          else $error("decode_issue_stage: pending counter underflow on r%0d", i);
`endif
      end
    end
  end

  // Register file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_valid) begin
      r_regs[wb_dest] <= wb_data;
    end
  end

  // Decode-to-execute register: flush beats accept, accept beats consume
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid       <= 1'b0;
      r_out_ctrl        <= '0;
      r_out_sr1         <= '0;
      r_out_sr2         <= '0;
      r_out_dest        <= '0;
      r_out_writes_dest <= 1'b0;
      r_out_imm         <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end else if (w_accept) begin
      r_out_valid       <= 1'b1;
      r_out_ctrl        <= in_ctrl;
      r_out_sr1         <= w_rd1;
      r_out_sr2         <= w_rd2;
      r_out_dest        <= in_dest;
      r_out_writes_dest <= in_writes_dest;
      r_out_imm         <= in_imm;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end
  end

  assign out_valid       = r_out_valid;
  assign out_ctrl        = r_out_ctrl;
  assign out_sr1         = r_out_sr1;
  assign out_sr2         = r_out_sr2;
  assign out_dest        = r_out_dest;
  assign out_writes_dest = r_out_writes_dest;
  assign out_imm         = r_out_imm;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_issue_stage
// Purpose : Directed self-checking bench for decode_issue_stage; issued
//           entries are predicted into a queue and checked when consumed.
// Revision: 1.0 - initial release
// ============================================================================
module tb_decode_issue_stage;

  typedef struct packed {
    logic [31:0] ctrl;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [2:0]  dest;
    logic        wd;
    logic [15:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ctrl;
  logic [2:0]  in_src1, in_src2, in_dest;
  logic        in_uses_src1, in_uses_src2, in_writes_dest;
  logic [15:0] in_imm;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ctrl;
  logic [15:0] out_sr1, out_sr2;
  logic [2:0]  out_dest;
  logic        out_writes_dest;
  logic [15:0] out_imm;
  logic        stall;

  int          n_cmp  = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  exp_t        m_e;
  logic [15:0] m_regs [8];

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
    .in_uses_src1(in_uses_src1), .in_uses_src2(in_uses_src2),
    .in_writes_dest(in_writes_dest), .in_imm(in_imm),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_sr1(out_sr1), .out_sr2(out_sr2), .out_dest(out_dest),
    .out_writes_dest(out_writes_dest), .out_imm(out_imm),
    .stall(stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [31:0] c, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input logic u1, input logic u2,
                       input logic wd, input logic [15:0] imm);
    in_valid = 1'b1; in_ctrl = c; in_src1 = s1; in_src2 = s2; in_dest = d;
    in_uses_src1 = u1; in_uses_src2 = u2; in_writes_dest = wd; in_imm = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_ctrl = '0; in_src1 = '0; in_src2 = '0; in_dest = '0;
    in_uses_src1 = 1'b0; in_uses_src2 = 1'b0; in_writes_dest = 1'b0; in_imm = '0;
  endtask

  task automatic wb(input logic v, input logic [2:0] d, input logic [15:0] data);
    wb_valid = v; wb_dest = d; wb_data = data;
  endtask

  // Operand value the stage should capture for source register s this cycle
  function automatic logic [15:0] rd(input logic [2:0] s);
`ifdef DECODE_ISSUE_BYPASS_EN
    if (wb_valid && wb_dest == s) return wb_data;
`endif
    return m_regs[s];
  endfunction

  // One cycle: check handshake, predict the issued entry, advance past the edge
  task automatic step(input string tag, input logic exp_rdy);
    exp_t e;
    #3;
    chk({tag, ".in_ready"}, in_ready, exp_rdy);
    chk({tag, ".stall"}, stall, in_valid & ~exp_rdy);
    if (in_valid && exp_rdy) begin
      e.ctrl = in_ctrl; e.sr1 = rd(in_src1); e.sr2 = rd(in_src2);
      e.dest = in_dest; e.wd = in_writes_dest; e.imm = in_imm;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (wb_valid && !reset) m_regs[wb_dest] = wb_data;
    #1;
  endtask

  // Scoreboard: compare entries as they are consumed, discard squashed ones
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_valid) begin
        chk("nop_ctrl", out_ctrl, 0);
      end else if (flush || out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", exp_q.size(), 1);
        end else begin
          m_e = exp_q.pop_front();
          if (!flush) begin
            chk("out_ctrl", out_ctrl, m_e.ctrl);
            chk("out_sr1", out_sr1, m_e.sr1);
            chk("out_sr2", out_sr2, m_e.sr2);
            chk("out_dest", out_dest, m_e.dest);
            chk("out_wd", out_writes_dest, m_e.wd);
            chk("out_imm", out_imm, m_e.imm);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    idle();
    wb(1'b0, 3'd0, 16'h0);
    repeat (3) begin @(posedge clk); #1; end

    // Reset state; nothing is accepted while reset is high
    instr(32'hDEAD, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 16'h1);
    step("rst", 1'b0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_ctrl", out_ctrl, 0);
    chk("rst.out_sr1", out_sr1, 0);
    chk("rst.out_imm", out_imm, 0);
    chk("rst.out_dest", out_dest, 0);
    idle();
    reset = 1'b0;
    step("idle", 1'b1);
    chk("idle.out_valid", out_valid, 0);

    // RAW hazard on R3 released by writeback
    instr(32'h11, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 16'h0011);
    step("wr3", 1'b1);
    instr(32'h22, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0022);
    step("raw0", 1'b0);
    step("raw1", 1'b0);
    step("raw2", 1'b0);
    wb(1'b1, 3'd3, 16'h1234);
`ifdef DECODE_ISSUE_BYPASS_EN
    step("raw_wb", 1'b1);
    wb(1'b0, 3'd0, 16'h0);
`else
    step("raw_wb", 1'b0);
    wb(1'b0, 3'd0, 16'h0);
    step("raw_issue", 1'b1);
`endif
    chk("raw.out_valid", out_valid, 1);
    chk("raw.out_sr1", out_sr1, 16'h1234);

    // Pending-counter saturation on R5
    instr(32'h51, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 16'h0051);
    step("sat_w1", 1'b1);
    instr(32'h52, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 16'h0052);
    step("sat_w2", 1'b1);
    instr(32'h53, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 16'h0053);
    step("sat_w3", 1'b1);
    instr(32'h54, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 16'h0054);
    step("sat0", 1'b0);
    step("sat1", 1'b0);
    wb(1'b1, 3'd5, 16'h0055);
    step("sat_wb", 1'b0);
    wb(1'b0, 3'd0, 16'h0);
    step("sat_issue", 1'b1);

    // Backpressure holds the entry, then back-to-back transfers
    out_ready = 1'b0;
    instr(32'h61, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0061);
    step("bp0", 1'b0);
    chk("bp0.out_valid", out_valid, 1);
    chk("bp0.out_ctrl", out_ctrl, 32'h54);
    chk("bp0.out_imm", out_imm, 16'h0054);
    step("bp1", 1'b0);
    chk("bp1.out_ctrl", out_ctrl, 32'h54);
    chk("bp1.out_imm", out_imm, 16'h0054);
    out_ready = 1'b1;
    step("bp_go", 1'b1);
    chk("bp_go.out_ctrl", out_ctrl, 32'h61);
    instr(32'h62, 3'd0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0062);
    step("b2b", 1'b1);
    chk("b2b.out_valid", out_valid, 1);
    chk("b2b.out_ctrl", out_ctrl, 32'h62);

    // Flush squashes a writer to R2 and releases its pending count
    instr(32'h71, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 16'h0071);
    step("fl_wr", 1'b1);
    instr(32'h72, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0072);
    flush = 1'b1;
    step("fl", 1'b0);
    flush = 1'b0;
    chk("fl.out_valid", out_valid, 0);
    chk("fl.out_ctrl", out_ctrl, 0);
    step("fl_after", 1'b1);

    // Same-cycle issue and retire on R4 leaves one write pending
    instr(32'h81, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1, 16'h0081);
    step("waw0", 1'b1);
    instr(32'h82, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1, 16'h0082);
    wb(1'b1, 3'd4, 16'h4444);
    step("waw_wb", 1'b1);
    wb(1'b0, 3'd0, 16'h0);
    instr(32'h83, 3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0083);
    step("waw_hold", 1'b0);
    wb(1'b1, 3'd4, 16'h4445);
`ifdef DECODE_ISSUE_BYPASS_EN
    step("waw_rel", 1'b1);
    wb(1'b0, 3'd0, 16'h0);
`else
    step("waw_rel", 1'b0);
    wb(1'b0, 3'd0, 16'h0);
    step("waw_issue", 1'b1);
`endif
    chk("waw.out_sr1", out_sr1, 16'h4445);

    // Drain R5 and read it back with R4
    idle();
    wb(1'b1, 3'd5, 16'h0501);
    step("dr5a", 1'b1);
    wb(1'b1, 3'd5, 16'h0502);
    step("dr5b", 1'b1);
    wb(1'b1, 3'd5, 16'h0503);
    step("dr5c", 1'b1);
    wb(1'b0, 3'd0, 16'h0);
    instr(32'h91, 3'd5, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0091);
    step("rd5", 1'b1);
    idle();
    repeat (4) step("tail", 1'b1);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
